spi_controller: RTL and testbench

- SPI mode-0 controller (master) in the single `sys_clk` domain; the initiator end of the 4-wire link our SPI peripheral responds on.
- Drives external ADC/peripheral pads (CSN, SCK, MOSI) and samples MISO.
- Exchanges one BYTE_W word per `start`, with optional CS hold for multi-word bursts.
- Consumed by DSP control logic through a start/ready/rx_valid handshake.

---
 rtl/spi_controller.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_controller.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 master: one BYTE_W word per accepted start, MSB first, with an
// optional chip-select hold (HELD) so several words can share one CSN-low burst.
//
// Handshake: a request is taken on a sys_clk edge where start=1 and ready=1.
// tx_data and keep_cs are sampled on that same edge. While ready=0, start is
// ignored and not queued. rx_valid is a single-cycle strobe; rx_data holds its
// value until the next strobe.
module spi_controller #(
    parameter int BYTE_W   = 8,
    parameter int CLK_DIV  = 6,
    parameter int CS_SETUP = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              keep_cs,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              ready,
    output logic              busy,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              spi_csn,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [2:0]        dbg_state
);

    localparam int MAX_CNT = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int BIT_W   = $clog2(BYTE_W + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CS_LAST  = CNT_W'(CS_SETUP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GAP   = 3'd1;
    localparam logic [2:0] ST_LEAD  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_HIGH  = 3'd4;
    localparam logic [2:0] ST_TRAIL = 3'd5;
    localparam logic [2:0] ST_HELD  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [BYTE_W-1:0] tx_sh_q, tx_sh_d;
    logic [BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic              keep_q, keep_d;
    logic              csn_q, csn_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic [BYTE_W-1:0] rx_data_q, rx_data_d;
    logic              miso_s1_q, miso_s2_q;
    logic              accept;

    assign accept = start && ready_q;

    // Next-state and registered-output computation for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        keep_d     = keep_q;
        csn_d      = csn_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        case (state_q)
            ST_IDLE, ST_HELD: begin
                if (accept) begin
                    tx_sh_d = tx_data;
                    keep_d  = keep_cs;
                    mosi_d  = tx_data[BYTE_W-1];
                    csn_d   = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    cnt_d   = '0;
                    // A held CSN already satisfied the lead time on the first word.
                    state_d = (state_q == ST_HELD) ? ST_LOW : ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (cnt_q == CS_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[BYTE_W-2:0], miso_s2_q};
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_q == BIT_LAST) begin
                        bit_d      = '0;
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        if (keep_q) begin
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_TRAIL;
                        end
                    end else begin
                        // Rotate rather than shift so MOSI always comes from bit MSB-1.
                        bit_d   = bit_q + BIT_W'(1);
                        tx_sh_d = {tx_sh_q[BYTE_W-2:0], tx_sh_q[BYTE_W-1]};
                        mosi_d  = tx_sh_q[BYTE_W-2];
                        state_d = ST_LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_TRAIL: begin
                if (cnt_q == CS_LAST) begin
                    cnt_d   = '0;
                    csn_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CS_LAST) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                keep_d  = 1'b0;
                csn_d   = 1'b1;
                sck_d   = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and all pad/handshake outputs; reset aborts any transfer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            keep_q     <= 1'b0;
            csn_q      <= 1'b1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            keep_q     <= keep_d;
            csn_q      <= csn_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Two-flop synchroniser for the asynchronous MISO pad.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign spi_csn   = csn_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a negedge monitor acting as SPI peripheral and
// link observer, plus one task per scenario checking against values derived
// from the link timing rules and the words exchanged.
module tb_spi_controller;

    localparam int BYTE_W   = 8;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CSN_LOW  = 2 * CS_SETUP + 2 * CLK_DIV * BYTE_W;
    localparam int RXV_OFS  = CS_SETUP + 2 * CLK_DIV * BYTE_W;
    localparam int WORD_CYC = 2 * CLK_DIV * BYTE_W;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              start;
    logic              keep_cs;
    logic [BYTE_W-1:0] tx_data;
    logic              ready;
    logic              busy;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              spi_csn;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic [2:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // 0 = peripheral model, 1 = MOSI looped back, 2 = tied high
    int          miso_mode = 0;
    logic        slave_miso = 1'b0;
    logic [7:0]  slave_word = 8'h00;
    logic [7:0]  slave_cap = 8'h00;
    int          slave_idx = 0;

    int cyc = 0;
    int sck_rises = 0;
    int sck_hi_run = 0;
    int sck_bad = 0;
    int sck_cs_err = 0;
    int csn_falls = 0;
    int csn_fall_cyc = 0;
    int csn_run = 0;
    int csn_last = 0;
    int gap_run = 0;
    int gap_last = 0;
    int mosi_chg = 0;
    int rxv_count = 0;
    int rxv_cyc = 0;
    int rxv_double = 0;
    logic prev_sck = 1'b0, prev_csn = 1'b1, prev_mosi = 1'b0, prev_rxv = 1'b0;

    logic [BYTE_W-1:0] exp_q[$];
    logic [BYTE_W-1:0] got_q[$];

    assign spi_miso = (miso_mode == 1) ? spi_mosi : ((miso_mode == 2) ? 1'b1 : slave_miso);

    spi_controller #(.BYTE_W(BYTE_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .keep_cs   (keep_cs),
        .tx_data   (tx_data),
        .ready     (ready),
        .busy      (busy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .spi_csn   (spi_csn),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 sys_clk = ~sys_clk;

    // link monitor and mode-0 peripheral, sampled on the inactive edge
    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (!sys_rst_n) begin
            csn_run    = 0;
            sck_hi_run = 0;
            gap_run    = 0;
        end else begin
            if (spi_csn && spi_sck) sck_cs_err++;
            if (!prev_sck && spi_sck) begin
                sck_rises++;
                slave_cap = {slave_cap[6:0], spi_mosi};
            end
            if (spi_sck) sck_hi_run++;
            if (prev_sck && !spi_sck) begin
                if (sck_hi_run != CLK_DIV) sck_bad++;
                sck_hi_run = 0;
                if (slave_idx > 0) begin
                    slave_idx  = slave_idx - 1;
                    slave_miso = slave_word[slave_idx];
                end
            end
            if (prev_csn && !spi_csn) begin
                csn_falls++;
                csn_fall_cyc = cyc;
                slave_idx    = 7;
                slave_miso   = slave_word[7];
            end
            if (!spi_csn) csn_run++;
            else if (!prev_csn) begin
                csn_last = csn_run;
                csn_run  = 0;
            end
            if (spi_csn && !ready) gap_run++;
            else if (gap_run > 0) begin
                gap_last = gap_run;
                gap_run  = 0;
            end
            if (!spi_csn && !prev_csn && spi_mosi !== prev_mosi) mosi_chg++;
            if (rx_valid) begin
                got_q.push_back(rx_data);
                rxv_count++;
                rxv_cyc = cyc;
                if (prev_rxv) rxv_double++;
            end
        end
        prev_sck  = spi_sck;
        prev_csn  = spi_csn;
        prev_mosi = spi_mosi;
        prev_rxv  = rx_valid;
    end

    task automatic cyc_step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mon();
        sck_rises = 0;
        csn_falls = 0;
        mosi_chg  = 0;
        rxv_count = 0;
        slave_cap = 8'h00;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [BYTE_W-1:0] d, input logic k);
        start   = 1'b1;
        tx_data = d;
        keep_cs = k;
        cyc_step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ready && spi_csn && !busy) begin
                ok = 1'b1;
                break;
            end
            cyc_step();
        end
        cyc_step();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        start     = 1'b0;
        keep_cs   = 1'b0;
        tx_data   = '0;
        repeat (3) cyc_step();
        n_cmp++;
        if ({spi_csn, spi_sck, spi_mosi, ready, busy, rx_valid} !== 6'b100100) begin
            n_err++;
            $display("FAIL reset_ctrl: got csn/sck/mosi/ready/busy/rxv=%b need 100100",
                     {spi_csn, spi_sck, spi_mosi, ready, busy, rx_valid});
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_rx_data: got %h need 00", rx_data);
        end
        sys_rst_n = 1'b1;
        repeat (2) cyc_step();
    endtask

    task automatic test_loopback();
        bit ok;
        miso_mode = 1;
        clear_mon();
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b0);
        wait_idle(300, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL loop_timeout: controller never returned idle"); end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL loop_rx: got %0d words first %h need 1 word %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
        n_cmp++;
        if (sck_rises != BYTE_W) begin n_err++; $display("FAIL loop_sck_rises: got %0d need %0d", sck_rises, BYTE_W); end
        n_cmp++;
        if (csn_last != CSN_LOW) begin n_err++; $display("FAIL loop_csn_low: got %0d need %0d", csn_last, CSN_LOW); end
        n_cmp++;
        if (rxv_cyc - csn_fall_cyc != RXV_OFS) begin
            n_err++;
            $display("FAIL loop_rxv_time: got %0d need %0d", rxv_cyc - csn_fall_cyc, RXV_OFS);
        end
        n_cmp++;
        if (gap_last != CS_SETUP) begin n_err++; $display("FAIL loop_gap: got %0d need %0d", gap_last, CS_SETUP); end
        n_cmp++;
        if (rx_data !== 8'hA5) begin n_err++; $display("FAIL loop_rx_hold: got %h need a5", rx_data); end
    endtask

    task automatic test_tie_one();
        bit ok;
        miso_mode = 2;
        clear_mon();
        send(8'h00, 1'b0);
        wait_idle(300, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL tie_timeout: controller never returned idle"); end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 8'hFF) begin
            n_err++;
            $display("FAIL tie_rx: got %0d words rx_data %h need 1 word ff", got_q.size(), rx_data);
        end
        n_cmp++;
        if (mosi_chg != 0) begin n_err++; $display("FAIL tie_mosi_const: got %0d changes need 0", mosi_chg); end
        n_cmp++;
        if (sck_rises != BYTE_W) begin n_err++; $display("FAIL tie_sck_rises: got %0d need %0d", sck_rises, BYTE_W); end
    endtask

    task automatic test_slave();
        bit ok;
        miso_mode  = 0;
        slave_word = 8'h3C;
        clear_mon();
        send(8'hC3, 1'b0);
        wait_idle(300, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL slave_timeout: controller never returned idle"); end
        n_cmp++;
        if (slave_cap !== 8'hC3) begin n_err++; $display("FAIL slave_mosi: got %h need c3", slave_cap); end
        n_cmp++;
        if (got_q.size() != 1 || rx_data !== 8'h3C) begin
            n_err++;
            $display("FAIL slave_rx: got %0d words rx_data %h need 1 word 3c", got_q.size(), rx_data);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] d;
        miso_mode = 0;
        for (int n = 0; n < 8; n++) begin
            clear_mon();
            d          = 8'($urandom_range(0, 255));
            slave_word = 8'($urandom_range(0, 255));
            exp_q.push_back(slave_word);
            send(d, 1'b0);
            wait_idle(300, ok);
            n_cmp++;
            if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0] || slave_cap !== d) begin
                n_err++;
                $display("FAIL rand_word%0d: got rx %h mosi %h words %0d ok %0d need rx %h mosi %h",
                         n, rx_data, slave_cap, got_q.size(), ok, exp_q[0], d);
            end
            n_cmp++;
            if (sck_rises != BYTE_W || csn_last != CSN_LOW) begin
                n_err++;
                $display("FAIL rand_timing%0d: got rises %0d csn %0d need %0d %0d",
                         n, sck_rises, csn_last, BYTE_W, CSN_LOW);
            end
        end
    endtask

    task automatic test_burst();
        bit ok;
        int w;
        miso_mode = 1;
        clear_mon();
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send(8'h12, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ready) begin ok = 1'b1; break; end
            cyc_step();
        end
        n_cmp++;
        if (!ok || rx_valid !== 1'b1) begin
            n_err++;
            $display("FAIL burst_hold_entry: got ok %0d rx_valid %b need 1 1", ok, rx_valid);
        end
        w = $urandom_range(0, 3);
        repeat (w) cyc_step();
        n_cmp++;
        if ({spi_csn, spi_sck, ready, busy} !== 4'b0010) begin
            n_err++;
            $display("FAIL burst_held: got csn/sck/ready/busy=%b need 0010", {spi_csn, spi_sck, ready, busy});
        end
        send(8'h34, 1'b0);
        wait_idle(300, ok);
        n_cmp++;
        if (!ok || csn_falls != 1 || sck_rises != 2 * BYTE_W) begin
            n_err++;
            $display("FAIL burst_link: got ok %0d csn_falls %0d rises %0d need 1 1 %0d", ok, csn_falls, sck_rises, 2 * BYTE_W);
        end
        n_cmp++;
        if (csn_last != 2 * CS_SETUP + 2 * WORD_CYC + w + 1) begin
            n_err++;
            $display("FAIL burst_csn_low: got %0d need %0d", csn_last, 2 * CS_SETUP + 2 * WORD_CYC + w + 1);
        end
        n_cmp++;
        if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            n_err++;
            $display("FAIL burst_rx: got %0d words last %h need 2 words 12 34", got_q.size(), rx_data);
        end
        n_cmp++;
        if (gap_last != CS_SETUP) begin n_err++; $display("FAIL burst_gap: got %0d need %0d", gap_last, CS_SETUP); end
    endtask

    task automatic test_ignore();
        bit ok;
        logic [7:0] d1, d2;
        miso_mode  = 0;
        clear_mon();
        d1         = 8'($urandom_range(0, 255));
        d2         = 8'($urandom_range(0, 255));
        slave_word = 8'($urandom_range(0, 255));
        exp_q.push_back(slave_word);
        send(d1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ready) begin ok = 1'b1; break; end
            start   = (spi_csn && !ready) ? 1'b1 : 1'($urandom_range(0, 1));
            tx_data = 8'($urandom_range(0, 255));
            keep_cs = 1'($urandom_range(0, 1));
            cyc_step();
        end
        n_cmp++;
        if (!ok || sck_rises != BYTE_W || csn_falls != 1 || rxv_count != 1) begin
            n_err++;
            $display("FAIL ignore_busy: got ok %0d rises %0d csn_falls %0d rxv %0d need 1 %0d 1 1",
                     ok, sck_rises, csn_falls, rxv_count, BYTE_W);
        end
        slave_word = 8'($urandom_range(0, 255));
        exp_q.push_back(slave_word);
        send(d2, 1'b0);
        wait_idle(300, ok);
        n_cmp++;
        if (!ok || csn_falls != 2 || sck_rises != 2 * BYTE_W || slave_cap !== d2) begin
            n_err++;
            $display("FAIL ignore_accept_after_gap: got ok %0d csn_falls %0d rises %0d mosi %h need 1 2 %0d %h",
                     ok, csn_falls, sck_rises, slave_cap, 2 * BYTE_W, d2);
        end
        n_cmp++;
        if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            n_err++;
            $display("FAIL ignore_rx: got %0d words last %h need %h %h", got_q.size(), rx_data, exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] d;
        miso_mode  = 0;
        clear_mon();
        slave_word = 8'($urandom_range(0, 255));
        send(8'($urandom_range(0, 255)), 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sck_rises >= 4) begin ok = 1'b1; break; end
            cyc_step();
        end
        sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (!ok || {spi_csn, spi_sck, ready, busy, rx_valid} !== 5'b10100) begin
            n_err++;
            $display("FAIL midreset_abort: got ok %0d csn/sck/ready/busy/rxv=%b need 1 10100",
                     ok, {spi_csn, spi_sck, ready, busy, rx_valid});
        end
        repeat (2) cyc_step();
        n_cmp++;
        if (rxv_count != 0) begin n_err++; $display("FAIL midreset_rxv: got %0d need 0", rxv_count); end
        sys_rst_n = 1'b1;
        cyc_step();
        clear_mon();
        d          = 8'($urandom_range(0, 255));
        slave_word = 8'($urandom_range(0, 255));
        exp_q.push_back(slave_word);
        send(d, 1'b0);
        wait_idle(300, ok);
        n_cmp++;
        if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0] || slave_cap !== d
            || sck_rises != BYTE_W || csn_last != CSN_LOW) begin
            n_err++;
            $display("FAIL midreset_recover: got rx %h mosi %h rises %0d csn %0d need %h %h %0d %0d",
                     rx_data, slave_cap, sck_rises, csn_last, exp_q[0], d, BYTE_W, CSN_LOW);
        end
    endtask

    task automatic test_link_rules();
        n_cmp++;
        if (sck_cs_err != 0) begin n_err++; $display("FAIL sck_while_csn_high: got %0d need 0", sck_cs_err); end
        n_cmp++;
        if (sck_bad != 0) begin n_err++; $display("FAIL sck_high_width: got %0d bad pulses need 0", sck_bad); end
        n_cmp++;
        if (rxv_double != 0) begin n_err++; $display("FAIL rx_valid_width: got %0d long strobes need 0", rxv_double); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_tie_one();
        test_slave();
        test_random();
        test_burst();
        test_ignore();
        test_reset_mid();
        test_link_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
